pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width; legal values are powers of two, 4..64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width and pipeline depth (not overridable).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream presents an operation.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_shamt  input  SHW  shift amount, 0..WIDTH-1, unsigned.
REQ-009 SHALL have port in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_data  output  WIDTH  shifted result.
REQ-013 SHALL have port out_zero  output  1  high when out_data is all zeros, qualified by out_valid.

Function
REQ-014 SHALL transfer an input when in_valid && in_ready and an output when out_valid && out_ready.
REQ-015 SHALL implement SHW registered stages; stage k shifts by 2^k when shamt bit k is set, else passes through.
REQ-016 SHALL give latency exactly SHW cycles from input transfer to out_valid when out_ready is held high.
REQ-017 SHALL carry valid, remaining shamt bits and mode alongside the data in every stage.
REQ-018 SHALL use a global stall: stall = out_valid && !out_ready; while stalled no stage register changes.
REQ-019 SHALL drive in_ready = !stall (combinational, no dependency on in_valid).
REQ-020 SHALL keep bubbles in place; the pipeline does not collapse empty stages.
REQ-021 SHALL sustain one transfer per cycle with out_ready held high (throughput 1).
REQ-022 SHALL fill with 0 for LSL/LSR, with in_data[WIDTH-1] for ASR, and wrap LSBs into MSBs for ROR.
REQ-023 SHALL pass in_data unchanged for in_shamt = 0 in every mode.
REQ-024 SHALL hold out_data, out_zero and out_valid stable while stalled.
REQ-025 SHALL compute out_zero from the final-stage data register, not from a separate pipeline.
REQ-026 SHALL ignore in_data, in_shamt and in_mode when in_valid is low; stage valid bit becomes 0.

Reset
REQ-027 SHALL, on rst_n low, immediately clear every stage valid bit; out_valid = 0, out_zero = 0, out_data = 0.
REQ-028 SHALL drop all in-flight operations when reset asserts mid-operation; none appear after release.
REQ-029 SHALL drive in_ready = 1 during and after reset (no stall is possible with out_valid = 0).
REQ-030 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL recognise macro BARREL_SHIFTER_ROTATE_EN.
REQ-032 SHALL, with BARREL_SHIFTER_ROTATE_EN defined, implement mode 11 as rotate right.
REQ-033 SHALL, without BARREL_SHIFTER_ROTATE_EN, execute mode 11 identically to LSR (01) and omit the wrap datapath.

Verification
REQ-034 SHALL cover: WIDTH=8, LSL, data 0x96, shamt 3, out_ready=1 -> after 3 cycles out_data 0xB0, out_zero 0.
REQ-035 SHALL cover: WIDTH=8, ASR 0x96 shamt 2 -> 0xE5; LSR 0x96 shamt 2 -> 0x25; ROR 0x96 shamt 4 -> 0x69 (with macro), 0x09 (without).
REQ-036 SHALL cover: back-to-back 8 ops, out_ready=1 -> 8 results in order on 8 consecutive cycles, first 3 cycles after first accept.
REQ-037 SHALL cover: out_ready low 5 cycles while out_valid=1 -> in_ready=0, out_data stable, no loss or duplication after release.
REQ-038 SHALL cover: LSR 0x01 shamt 1 -> out_data 0x00 with out_zero 1; shamt 0 in each mode -> data unchanged.
REQ-039 SHALL cover: rst_n pulsed low with 3 ops in flight -> out_valid 0 at once, no stale result after release, next op correct.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, global stall.
// Define BARREL_SHIFTER_ROTATE_EN to turn mode 11 into rotate right; otherwise it behaves as LSR.

module pipelined_barrel_shifter_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [SHW-1:0]   prev_shamt,
  input  logic [1:0]       prev_mode,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   shamt,
  output logic [1:0]       mode
);
  localparam int D = 1 << K;

  logic [WIDTH-1:0] shifted;

  // ASR fill uses the current MSB: earlier ASR stages preserve the original sign.
  always_comb begin
    shifted = prev_data;
    if (prev_shamt[K]) begin
      case (prev_mode)
        2'b00:   shifted = {prev_data[WIDTH-1-D:0], {D{1'b0}}};
        2'b10:   shifted = {{D{prev_data[WIDTH-1]}}, prev_data[WIDTH-1:D]};
`ifdef BARREL_SHIFTER_ROTATE_EN
        2'b11:   shifted = {prev_data[D-1:0], prev_data[WIDTH-1:D]};
`endif
        default: shifted = {{D{1'b0}}, prev_data[WIDTH-1:D]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      mode  <= '0;
    end else if (en) begin
      valid <= prev_valid;
      data  <= shifted;
      shamt <= prev_shamt;
      mode  <= prev_mode;
    end
  end
endmodule

module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  logic [SHW:0]            vld_pipe;
  logic [SHW:0][WIDTH-1:0] data_pipe;
  logic [SHW:0][SHW-1:0]   shamt_pipe;
  logic [SHW:0][1:0]       mode_pipe;
  logic                    stall;
  logic                    unused_side;

  // Index 0 is the unregistered input; index k+1 is the register of stage k.
  assign vld_pipe[0]   = in_valid;
  assign data_pipe[0]  = in_data;
  assign shamt_pipe[0] = in_shamt;
  assign mode_pipe[0]  = in_mode;

  assign stall    = vld_pipe[SHW] && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    pipelined_barrel_shifter_stage #(
      .WIDTH(WIDTH),
      .SHW  (SHW),
      .K    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (!stall),
      .prev_valid(vld_pipe[k]),
      .prev_data (data_pipe[k]),
      .prev_shamt(shamt_pipe[k]),
      .prev_mode (mode_pipe[k]),
      .valid     (vld_pipe[k+1]),
      .data      (data_pipe[k+1]),
      .shamt     (shamt_pipe[k+1]),
      .mode      (mode_pipe[k+1])
    );
  end

  // Sideband leaving the last stage has no consumer.
  assign unused_side = ^{shamt_pipe[SHW], mode_pipe[SHW]};

  assign out_valid = vld_pipe[SHW];
  assign out_data  = data_pipe[SHW];
  assign out_zero  = vld_pipe[SHW] && (data_pipe[SHW] == '0);
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed table-driven bench for pipelined_barrel_shifter (WIDTH=8), plus stream, stall and reset sequences.
module tb_pipelined_barrel_shifter;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int NVEC  = 16;
`ifdef BARREL_SHIFTER_ROTATE_EN
  localparam bit ROR_ON = 1'b1;
`else
  localparam bit ROR_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [2:0] shamt;
    logic [1:0] mode;
    logic [7:0] exp;
    logic       exp_zero;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_shamt = '0;
  logic [1:0] in_mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_zero;

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[NVEC];

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [7:0] d, logic [2:0] s, logic [1:0] m, logic [7:0] e);
    vec_t v;
    v.data = d; v.shamt = s; v.mode = m; v.exp = e; v.exp_zero = (e == 8'h00);
    return v;
  endfunction

  task automatic drive(int i);
    in_valid = 1'b1;
    in_data  = vecs[i].data;
    in_shamt = vecs[i].shamt;
    in_mode  = vecs[i].mode;
  endtask

  // Call at the negedge right after the accepting posedge; counts edges until out_valid.
  task automatic wait_result(int i);
    int lat;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency[%0d]", i), 32'(lat), 32'(SHW));
    check($sformatf("data[%0d]", i), 32'(out_data), 32'(vecs[i].exp));
    check($sformatf("zero[%0d]", i), 32'(out_zero), 32'(vecs[i].exp_zero));
    @(negedge clk);
    check($sformatf("single_drop[%0d]", i), 32'(out_valid), 32'(0));
  endtask

  task automatic send_one(int i);
    @(negedge clk);
    drive(i);
    @(negedge clk);
    wait_result(i);
  endtask

  task automatic run_stream(int n, int stall_at, int stall_len);
    int exp_q[$];
    int idx, got, k, stalls;
    idx = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (idx < n) drive(idx);
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        check("stall_in_ready", 32'(in_ready), 32'(0));
        if (exp_q.size() > 0) check("stall_hold", 32'(out_data), 32'(vecs[exp_q[0]].exp));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_dup: got unexpected result %0h expected none", out_data);
        end else begin
          k = exp_q.pop_front();
          check($sformatf("stream_data[%0d]", k), 32'(out_data), 32'(vecs[k].exp));
          check($sformatf("stream_zero[%0d]", k), 32'(out_zero), 32'(vecs[k].exp_zero));
          if (stall_len == 0) check($sformatf("stream_cycle[%0d]", k), 32'(cyc), 32'(got + SHW));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(idx);
        idx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(got), 32'(n));
    check("stall_cycles", 32'(stalls), 32'(stall_len));
  endtask

  initial begin
    int stale;
    vecs[0]  = mk(8'h96, 3'd3, 2'b00, 8'hB0);
    vecs[1]  = mk(8'h96, 3'd2, 2'b10, 8'hE5);
    vecs[2]  = mk(8'h96, 3'd2, 2'b01, 8'h25);
    vecs[3]  = mk(8'h96, 3'd4, 2'b11, ROR_ON ? 8'h69 : 8'h09);
    vecs[4]  = mk(8'h01, 3'd1, 2'b01, 8'h00);
    vecs[5]  = mk(8'hA5, 3'd0, 2'b00, 8'hA5);
    vecs[6]  = mk(8'hA5, 3'd0, 2'b01, 8'hA5);
    vecs[7]  = mk(8'hA5, 3'd0, 2'b10, 8'hA5);
    vecs[8]  = mk(8'hA5, 3'd0, 2'b11, 8'hA5);
    vecs[9]  = mk(8'h01, 3'd7, 2'b00, 8'h80);
    vecs[10] = mk(8'h80, 3'd7, 2'b10, 8'hFF);
    vecs[11] = mk(8'h80, 3'd7, 2'b01, 8'h01);
    vecs[12] = mk(8'h01, 3'd1, 2'b11, ROR_ON ? 8'h80 : 8'h00);
    vecs[13] = mk(8'h7F, 3'd3, 2'b10, 8'h0F);
    vecs[14] = mk(8'h3C, 3'd5, 2'b11, ROR_ON ? 8'hE1 : 8'h01);
    vecs[15] = mk(8'hC3, 3'd1, 2'b10, 8'hE1);

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_zero", 32'(out_zero), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(negedge clk);

    // Release reset and present an op on the same cycle: first edge must accept it.
    rst_n = 1'b1;
    drive(0);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    wait_result(0);

    for (int i = 0; i < NVEC; i++) send_one(i);

    run_stream(8, 1000, 0);
    run_stream(8, 3, 5);

    // Reset with three ops in flight
    @(negedge clk); drive(1);
    @(negedge clk); drive(2);
    @(negedge clk); drive(3);
    @(negedge clk); in_valid = 1'b0;
    #1;
    check("mid_pre_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_data", 32'(out_data), 32'(0));
    check("mid_rst_zero", 32'(out_zero), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", 32'(stale), 32'(0));
    send_one(15);
    send_one(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
